// File: rtl/unidade_controle_exp4_pkg.sv
// Shared definitions for the exp4 control unit: state codes (also shown on
// the 7-segment debug display), state width, timeout defaults and the
// Moore output decode. The TIMEOUT_EN build also uses this package.
package unidade_controle_exp4_pkg;

  localparam int STATE_W                = 4;
  localparam int TIMEOUT_W              = 13;
  localparam int TIMEOUT_CYCLES_DEFAULT = 5000;

  typedef enum logic [STATE_W-1:0] {
    INICIAL       = 4'b0000,
    PREPARACAO    = 4'b0001,
    ESPERA_JOGADA = 4'b0010,
    REGISTRA      = 4'b0100,
    COMPARACAO    = 4'b0101,
    PROXIMO       = 4'b0110,
    FIM_ACERTO    = 4'b1010,
    FIM_ERRO      = 4'b1110,
    FIM_TIMEOUT   = 4'b1101
  } estado_t;

  typedef struct packed {
    logic zera_c;
    logic conta_c;
    logic zera_r;
    logic registra_r;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
  } saidas_t;

  // Moore decode: every output is a pure function of the state.
  function automatic saidas_t decodifica(input estado_t e);
    saidas_t s;
    s = '0;
    case (e)
      PREPARACAO: begin
        s.zera_c = 1'b1;
        s.zera_r = 1'b1;
      end
      REGISTRA:   s.registra_r = 1'b1;
      PROXIMO:    s.conta_c    = 1'b1;
      FIM_ACERTO: begin
        s.pronto  = 1'b1;
        s.acertou = 1'b1;
      end
      FIM_ERRO: begin
        s.pronto = 1'b1;
        s.errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        s.pronto  = 1'b1;
        s.timeout = 1'b1;
      end
      default:    s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/unidade_controle_exp4_edge_detector.sv
// Rising-edge detector: one-cycle pulse on each 0->1 transition of sinal.
// The history register is updated every cycle, so a held level yields a
// single pulse no matter what the consumer is doing.
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic pulso
);

  logic sinal_q;
  logic sinal_d;

  // Next value of the history register: always the current input level.
  always_comb begin
    sinal_d = sinal;
  end

  // History register with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sinal_q <= 1'b0;
    end else begin
      sinal_q <= sinal_d;
    end
  end

  assign pulso = sinal & ~sinal_q;

endmodule

// File: rtl/unidade_controle_exp4.sv
// Control unit for the exp4 play-through: sequences counter/register
// clears, per-position load/compare/advance, and the final result states.
// Optional feature: define TIMEOUT_EN to enable the move timeout
// (TIMEOUT_CYCLES cycles in espera_jogada -> fim_timeout).
module unidade_controle_exp4
  import unidade_controle_exp4_pkg::*;
`ifdef TIMEOUT_EN
  #(parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT)
`endif
(
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               jogada,
  input  logic               igual,
  input  logic               fimC,
  output logic               zeraC,
  output logic               contaC,
  output logic               zeraR,
  output logic               registraR,
  output logic               pronto,
  output logic               acertou,
  output logic               errou,
  output logic               timeout,
  output logic [STATE_W-1:0] db_estado
);

  estado_t estado_q;
  estado_t estado_d;
  saidas_t saidas_q;
  saidas_t saidas_d;
  logic    jogada_pulso;

  edge_detector u_jogada_edge (
    .clock (clock),
    .reset (reset),
    .sinal (jogada),
    .pulso (jogada_pulso)
  );

`ifdef TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] tmo_q;
  logic [TIMEOUT_W-1:0] tmo_d;
  logic                 tmo_fim;

  // Wait counter: counts cycles spent in espera_jogada, zero elsewhere so
  // every entry starts from zero.
  always_comb begin
    if (estado_q == ESPERA_JOGADA) begin
      tmo_d = tmo_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    end else begin
      tmo_d = {TIMEOUT_W{1'b0}};
    end
  end

  // Wait counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_q <= {TIMEOUT_W{1'b0}};
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign tmo_fim = (tmo_q == TIMEOUT_LAST);
`endif

  // Next-state logic; outputs are decoded from the next state so they are
  // registered yet line up exactly with the state they belong to.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL: begin
        if (iniciar) estado_d = PREPARACAO;
        else         estado_d = INICIAL;
      end
      PREPARACAO:    estado_d = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        // A move in the terminal-count cycle still wins over the timeout.
        if (jogada_pulso)  estado_d = REGISTRA;
`ifdef TIMEOUT_EN
        else if (tmo_fim)  estado_d = FIM_TIMEOUT;
`endif
        else               estado_d = ESPERA_JOGADA;
      end
      REGISTRA:      estado_d = COMPARACAO;
      COMPARACAO: begin
        // Mismatch has priority over the last position.
        if (!igual)     estado_d = FIM_ERRO;
        else if (fimC)  estado_d = FIM_ACERTO;
        else            estado_d = PROXIMO;
      end
      PROXIMO:       estado_d = ESPERA_JOGADA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
        if (iniciar) estado_d = PREPARACAO;
        else         estado_d = estado_q;
      end
      default:       estado_d = INICIAL;
    endcase

    saidas_d = decodifica(estado_d);
`ifndef TIMEOUT_EN
    saidas_d.timeout = 1'b0;
`endif
  end

  // State and output registers, asynchronously forced to inicial/all-zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= INICIAL;
      saidas_q <= '0;
    end else begin
      estado_q <= estado_d;
      saidas_q <= saidas_d;
    end
  end

  assign zeraC     = saidas_q.zera_c;
  assign contaC    = saidas_q.conta_c;
  assign zeraR     = saidas_q.zera_r;
  assign registraR = saidas_q.registra_r;
  assign pronto    = saidas_q.pronto;
  assign acertou   = saidas_q.acertou;
  assign errou     = saidas_q.errou;
  assign timeout   = saidas_q.timeout;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_exp4.sv
// Self-checking bench for unidade_controle_exp4: directed scenarios with
// hand-computed expectations plus randomized stimulus, all compared every
// cycle against a behavioural game model (phase + step within a position).
module tb_unidade_controle_exp4;

  localparam int TC = 8;

  // model phases
  localparam int P_IDLE = 0;
  localparam int P_PREP = 1;
  localparam int P_PLAY = 2;
  localparam int P_WIN  = 3;
  localparam int P_LOSE = 4;
  localparam int P_TMO  = 5;

  // hand-computed output vectors {db_estado, zeraC, contaC, zeraR, registraR,
  // pronto, acertou, errou, timeout}
  localparam logic [11:0] V_RESET  = {4'b0000, 8'b0000_0000};
  localparam logic [11:0] V_PREP   = {4'b0001, 8'b1010_0000};
  localparam logic [11:0] V_ESPERA = {4'b0010, 8'b0000_0000};
  localparam logic [11:0] V_REG    = {4'b0100, 8'b0001_0000};
  localparam logic [11:0] V_CMP    = {4'b0101, 8'b0000_0000};
  localparam logic [11:0] V_ACERTO = {4'b1010, 8'b0000_1100};
  localparam logic [11:0] V_ERRO   = {4'b1110, 8'b0000_1010};
  localparam logic [11:0] V_TMO    = {4'b1101, 8'b0000_1001};

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       jogada = 1'b0;
  logic       igual = 1'b1;
  logic       fimC = 1'b0;
  logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;
  int conta_cnt = 0;
  int reg_cnt = 0;

  // behavioural model state
  int   m_phase = P_IDLE;
  int   m_step = 0;
  int   m_wait = 0;
  logic m_jprev = 1'b0;

  // directed-expectation mailbox (written only by the driver)
  int          pin_seq = 0;
  int          pin_kind = 0;
  logic [11:0] pin_exp = 12'd0;
  int          pin_cnt = 0;
  string       pin_name = "";

  always #5 clock = ~clock;

`ifdef TIMEOUT_EN
  unidade_controle_exp4 #(.TIMEOUT_CYCLES(TC)) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .jogada    (jogada),
    .igual     (igual),
    .fimC      (fimC),
    .zeraC     (zeraC),
    .contaC    (contaC),
    .zeraR     (zeraR),
    .registraR (registraR),
    .pronto    (pronto),
    .acertou   (acertou),
    .errou     (errou),
    .timeout   (timeout),
    .db_estado (db_estado)
  );
`else
  unidade_controle_exp4 dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .jogada    (jogada),
    .igual     (igual),
    .fimC      (fimC),
    .zeraC     (zeraC),
    .contaC    (contaC),
    .zeraR     (zeraR),
    .registraR (registraR),
    .pronto    (pronto),
    .acertou   (acertou),
    .errou     (errou),
    .timeout   (timeout),
    .db_estado (db_estado)
  );
`endif

  wire [11:0] dut_vec = {db_estado, zeraC, contaC, zeraR, registraR,
                         pronto, acertou, errou, timeout};

  // Expected outputs from the game situation.
  function automatic logic [11:0] model_vec(input int ph, input int st);
    logic [3:0] c;
    logic [7:0] o;
    c = 4'd0;
    o = 8'd0;
    if (ph == P_PREP) begin
      c = 4'd1;  o = 8'b1010_0000;
    end else if (ph == P_PLAY) begin
      if (st == 0)      c = 4'd2;
      else if (st == 1) begin c = 4'd4; o = 8'b0001_0000; end
      else if (st == 2) c = 4'd5;
      else              begin c = 4'd6; o = 8'b0100_0000; end
    end else if (ph == P_WIN) begin
      c = 4'd10; o = 8'b0000_1100;
    end else if (ph == P_LOSE) begin
      c = 4'd14; o = 8'b0000_1010;
    end else if (ph == P_TMO) begin
      c = 4'd13; o = 8'b0000_1001;
    end
    return {c, o};
  endfunction

  // Game model: a play is a sequence of positions; each accepted move takes
  // register (step 1), compare (step 2), then either ends or advances (step 3).
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_phase <= P_IDLE;
      m_step  <= 0;
      m_wait  <= 0;
      m_jprev <= 1'b0;
    end else begin
      m_jprev <= jogada;
      if (m_phase == P_PREP) begin
        m_phase <= P_PLAY;
        m_step  <= 0;
        m_wait  <= 0;
      end else if (m_phase == P_PLAY) begin
        if (m_step == 0) begin
          if (jogada && !m_jprev) m_step <= 1;
`ifdef TIMEOUT_EN
          else if (m_wait == TC - 1) m_phase <= P_TMO;
`endif
          else m_wait <= m_wait + 1;
        end else if (m_step == 1) begin
          m_step <= 2;
        end else if (m_step == 2) begin
          if (!igual)     m_phase <= P_LOSE;
          else if (fimC)  m_phase <= P_WIN;
          else            m_step <= 3;
        end else begin
          m_step <= 0;
          m_wait <= 0;
        end
      end else begin
        if (iniciar) m_phase <= P_PREP;
      end
    end
  end

  // Compare process: every cycle against the model, plus directed pins.
  initial begin
    int last_seq;
    logic [11:0] mv;
    last_seq = 0;
    forever begin
      @(negedge clock);
      mv = model_vec(m_phase, m_step);
      checks++;
      if (dut_vec !== mv) begin
        errors++;
        $display("FAIL cycle_compare t=%0t dut=%h model=%h", $time, dut_vec, mv);
      end
      if (contaC === 1'b1)    conta_cnt++;
      if (registraR === 1'b1) reg_cnt++;
      if (pin_seq != last_seq) begin
        last_seq = pin_seq;
        if (pin_kind == 0) begin
          checks++;
          if (dut_vec !== pin_exp) begin
            errors++;
            $display("FAIL %s dut=%h expected=%h", pin_name, dut_vec, pin_exp);
          end
          checks++;
          if (mv !== pin_exp) begin
            errors++;
            $display("FAIL %s_model model=%h expected=%h", pin_name, mv, pin_exp);
          end
        end else if (pin_kind == 1) begin
          checks++;
          if (conta_cnt != pin_cnt) begin
            errors++;
            $display("FAIL %s contaC_pulses=%0d expected=%0d", pin_name, conta_cnt, pin_cnt);
          end
        end else begin
          checks++;
          if (reg_cnt != pin_cnt) begin
            errors++;
            $display("FAIL %s registraR_pulses=%0d expected=%0d", pin_name, reg_cnt, pin_cnt);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic pin_vec(input string name, input logic [11:0] e);
    pin_name = name;
    pin_kind = 0;
    pin_exp  = e;
    pin_seq++;
  endtask

  task automatic pin_count(input string name, input int kind, input int n);
    pin_name = name;
    pin_kind = kind;
    pin_cnt  = n;
    pin_seq++;
  endtask

  // One move from espera_jogada; returns to espera_jogada unless the play ends.
  task automatic move(input logic ig, input logic fc);
    igual  = ig;
    fimC   = fc;
    jogada = 1'b1;
    tick(1);
    jogada = 1'b0;
    tick(3);
  endtask

  // Stimulus driver.
  initial begin
    int base;
    #1 reset = 1'b1;
    tick(2);
    pin_vec("reset_state", V_RESET);
    tick(1);
    reset = 1'b0;
    tick(1);

    // full success over 16 positions
    base = conta_cnt;
    iniciar = 1'b1; tick(1); iniciar = 1'b0;
    pin_vec("preparacao", V_PREP);
    tick(1);
    pin_vec("espera_after_prep", V_ESPERA);
    for (int i = 0; i < 16; i++) move(1'b1, (i == 15));
    pin_vec("fim_acerto", V_ACERTO);
    tick(1);
    pin_count("conta_15_pulses", 1, base + 15);
    tick(1);
    fimC = 1'b0;

    // error at position 3, with fimC high to show mismatch priority
    base = conta_cnt;
    iniciar = 1'b1; tick(1); iniciar = 1'b0; tick(1);
    for (int i = 0; i < 3; i++) move(1'b1, 1'b0);
    igual = 1'b0; fimC = 1'b1; jogada = 1'b1;
    tick(1);
    pin_vec("registra_n1", V_REG);
    jogada = 1'b0;
    tick(1);
    pin_vec("comparacao_n2", V_CMP);
    tick(1);
    pin_vec("fim_erro_n3", V_ERRO);
    tick(1);
    pin_count("conta_3_pulses", 1, base + 3);
    tick(1);

    // restart from fim_erro
    igual = 1'b1; fimC = 1'b0;
    iniciar = 1'b1; tick(1); iniciar = 1'b0;
    pin_vec("restart_prep", V_PREP);
    tick(1);
    pin_vec("restart_espera", V_ESPERA);

    // jogada held for 20 cycles -> one load
    base = reg_cnt;
    jogada = 1'b1;
    tick(20);
    pin_count("hold_one_registraR", 2, base + 1);
    tick(1);
    pin_vec("hold_back_in_espera", V_ESPERA);
    jogada = 1'b0;
    tick(1);

    // jogada rising during preparacao is ignored
    move(1'b0, 1'b0);
    base = reg_cnt;
    iniciar = 1'b1; tick(1); iniciar = 1'b0;
    jogada = 1'b1;
    tick(3);
    pin_vec("prep_jogada_ignored", V_ESPERA);
    tick(1);
    pin_count("prep_no_registraR", 2, base);
    jogada = 1'b0; igual = 1'b1;
    tick(1);

    // asynchronous reset mid-espera_jogada, observed before the next edge
    #1 reset = 1'b1;
    pin_vec("async_reset", V_RESET);
    tick(1);
    reset = 1'b0;
    tick(1);

`ifdef TIMEOUT_EN
    iniciar = 1'b1; tick(1); iniciar = 1'b0; tick(1);
    tick(7);
    pin_vec("tmo_not_yet", V_ESPERA);
    tick(1);
    pin_vec("tmo_fire", V_TMO);
    iniciar = 1'b1; tick(1); iniciar = 1'b0; tick(1);
    tick(7);
    jogada = 1'b1;
    tick(1);
    pin_vec("tmo_jogada_wins", V_REG);
    jogada = 1'b0;
    tick(3);
`endif

    // randomized play
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 499) == 0);
      iniciar = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 2) == 0) jogada = ~jogada;
      igual   = ($urandom_range(0, 15) != 0);
      fimC    = ($urandom_range(0, 5) == 0);
      tick(1);
    end
    reset = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unidade_controle_exp4.md
Name: unidade_controle_exp4

Overview:
- Moore FSM that sequences the counter/comparator datapath for a play-through of up to 16 positions.
- On `iniciar`, clears the counter and the switch register, then loops per position: wait for a player move, register the switches, check the compare result, advance the counter.
- Ends in a success state (all positions match) or an error state (first mismatch). Outputs reach the datapath enables and the board LEDs at the top level.

Parameters:
- TIMEOUT_CYCLES, 5000, cycles allowed in espera_jogada before timeout (used only with TIMEOUT_EN).

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; forces state inicial
- iniciar  input  1  start request, level, sampled each cycle
- jogada  input  1  player move, level (OR of buttons); internally edge-detected
- igual  input  1  datapath compare result: registered switches equal expected value
- fimC  input  1  datapath counter terminal count (rco), position 15 reached
- zeraC  output  1  counter clear
- contaC  output  1  counter enable
- zeraR  output  1  switch-register clear
- registraR  output  1  switch-register load
- pronto  output  1  play finished
- acertou  output  1  finished with all positions matched
- errou  output  1  finished on mismatch
- timeout  output  1  finished on timeout; constant 0 without TIMEOUT_EN
- db_estado  output  4  current state code, for 7-segment debug

Behaviour:
- Single clock domain. Reset is asynchronous and active-high. All outputs are decoded from the state register only (Moore, no input-to-output paths).
- Reset values: state = inicial; every output 0; db_estado = 0000; jogada edge register = 0; timeout counter = 0.
- State codes (db_estado): inicial 0000, preparacao 0001, espera_jogada 0010, registra 0100, comparacao 0101, proximo 0110, fim_acerto 1010, fim_erro 1110, fim_timeout 1101.
- jogada_pulso = jogada & ~jogada_q, where jogada_q is a register that is always updated. Holding jogada high produces exactly one pulse.
- Transitions:
  - inicial: iniciar=1 -> preparacao; else stay.
  - preparacao: zeraC=1, zeraR=1; unconditional -> espera_jogada.
  - espera_jogada: jogada_pulso=1 -> registra; else stay.
  - registra: registraR=1; -> comparacao.
  - comparacao: igual=0 -> fim_erro; igual=1 and fimC=1 -> fim_acerto; igual=1 and fimC=0 -> proximo.
  - proximo: contaC=1 for exactly one cycle; -> espera_jogada.
  - fim_acerto: pronto=1, acertou=1.
  - fim_erro: pronto=1, errou=1.
  - fim_timeout: pronto=1, timeout=1.
  - All three fim states: iniciar=1 -> preparacao (restart); else hold.
- Latency: jogada rise seen in cycle N -> registra in N+1 -> comparacao in N+2 -> result state in N+3. pronto is asserted in cycle N+3.
- igual and fimC are evaluated only in comparacao, which is one cycle after registraR, so register data is already stable.
- iniciar is ignored outside inicial and the fim states. jogada edges outside espera_jogada are ignored and not queued.
- Mismatch takes priority over fimC (fimC=1 with igual=0 -> fim_erro).
- Unused state codes (0011, 0111, 1000, 1001, 1011, 1100, 1111) -> inicial on the next clock.
- Reset mid-play returns to inicial in the same cycle, independent of the clock. The datapath is not cleared until the next preparacao.

Optional Feature:
- Macro TIMEOUT_EN.
- With it: a 13-bit counter clears on every entry to espera_jogada and increments each cycle spent there. Reaching TIMEOUT_CYCLES-1 with no jogada_pulso -> fim_timeout. If jogada_pulso and terminal count occur in the same cycle, the jogada wins.
- Without it: counter logic is absent, fim_timeout is unreachable, and timeout is tied to 0.

Decomposition:
- Shared package/include holds the state-code constants, the state width (4), and the TIMEOUT_CYCLES default. The datapath debug decoder and the testbench use the same file.
- One sub-module: edge_detector (clock, reset, sinal -> pulso), also reusable for iniciar by the top level.

Test Plan:
- Reset mid-espera_jogada: assert reset asynchronously -> db_estado=0000 and all outputs 0 before the next clock edge.
- Full success: iniciar pulse, 16 jogada pulses with igual=1, fimC=1 only at the 16th comparacao -> contaC pulses 15 times, then pronto=1, acertou=1, db_estado=1010.
- Error at position 3: igual=0 on the 4th comparacao -> fim_erro in cycle N+3 after that jogada rise; contaC pulsed exactly 3 times; errou=1.
- jogada held high for 20 cycles -> exactly one registraR pulse. A jogada pulse during preparacao -> ignored.
- Restart from fim_erro: iniciar=1 -> preparacao with zeraC=zeraR=1 for one cycle, then 0010.
- TIMEOUT_EN with TIMEOUT_CYCLES=8: no jogada for 8 cycles -> fim_timeout (1101), timeout=1. Jogada at the 8th cycle -> registra instead.
